pwm_duty_streamer: RTL and testbench
====================================

Name: pwm_duty_streamer

Overview:
- Upstream feeder for the PWM output stage in the TinyFPGA BX playground.
- Accepts a stream of duty-cycle samples over a valid/ready interface and buffers them in a small FIFO.
- Generates its own PWM ramp and applies one new duty value per PWM period, always at the period boundary, so the output never glitches mid-period.
- Replaces free-running duty ramps with host- or generator-driven sample playback (tones, fades) on a single output pin.

Parameters:
- DATA_W, 8: duty/sample width; PWM period = 2^DATA_W ticks.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, >= 2.
- DIV, 1: clocks per PWM tick (prescaler); >= 1.

Ports:
- CLK, input, 1: system clock (20 MHz PLL output in the BX top).
- RST, input, 1: synchronous, active-high reset.
- enable, input, 1: run PWM counter and consume samples.
- s_valid, input, 1: upstream sample valid.
- s_ready, output, 1: FIFO can accept a sample.
- s_data, input, DATA_W: duty sample.
- underrun_clr, input, 1: clears sticky underrun flag.
- pwm_out, output, 1: registered PWM output.
- period_stb, output, 1: one-cycle pulse at each period boundary.
- underrun, output, 1: sticky; set when a boundary finds the FIFO empty.
- fifo_level, output, $clog2(FIFO_DEPTH)+1: entries currently held.
- cur_duty, output, DATA_W: duty value applied this period.

Behaviour:
- Reset (RST=1 at a CLK edge) forces the following:
  - pwm_out=0, period_stb=0, underrun=0, cur_duty=0, fifo_level=0.
  - Prescaler=0, counter cnt=0, FIFO pointers=0.
  - s_ready=0 while RST is high; s_ready=1 in the first cycle after RST falls.
- Reset mid-period discards FIFO contents and the current period.
- FIFO:
  - Push when s_valid&&s_ready.
  - s_ready = (fifo_level < FIFO_DEPTH), from registered level only. No bypass: when full, a same-cycle pop does not raise s_ready.
  - Simultaneous push and pop leaves the level unchanged.
  - FIFO accepts pushes regardless of enable.
- Tick: the prescaler counts 0..DIV-1 while enable=1; tick = (prescaler==DIV-1). With DIV=1, tick fires every cycle.
- Counter: cnt (DATA_W bits) increments on each tick and wraps 2^DATA_W-1 -> 0.
- Boundary = tick && cnt==2^DATA_W-1. On a boundary cycle:
  - If the FIFO is non-empty: pop, and cur_duty <= head (visible next cycle).
  - If the FIFO is empty: cur_duty holds its value and underrun <= 1.
  - period_stb=1 for exactly that cycle (registered, so asserted the cycle after the boundary edge).
- pwm_out <= enable && (cnt < cur_duty), registered, one clock latency from cnt.
  - duty=0 gives a constant low output.
  - duty=2^DATA_W-1 gives high for 2^DATA_W-1 of 2^DATA_W ticks.
  - No 100% duty.
- enable=0:
  - Prescaler and cnt are forced to 0; pwm_out=0 on the next edge.
  - No pops and no underrun.
  - cur_duty is retained.
- After enable rises, the first period uses the retained cur_duty. The first pop occurs at the end of that period.
- underrun:
  - Cleared by underrun_clr.
  - If set and clear happen in the same cycle, set wins.
  - Only RST or underrun_clr clear it.
- Widths: all counters are unsigned. fifo_level never exceeds FIFO_DEPTH; pushes at full are impossible by construction.

Optional Feature:
- Macro: PWM_UNDERRUN_ZERO_EN.
- Defined: on an underrun boundary, cur_duty <= 0, so the output goes silent (low) until new data arrives. underrun is still set.
- Undefined: cur_duty holds its last value on underrun (default).

Test Plan:
- Reset check: RST high 3 cycles, then low -> all outputs 0; s_ready=1 one cycle after RST falls; fifo_level=0.
- Steady playback (DIV=1): push 0x40, 0x80, 0xFF; enable=1.
  - First 256-clock period uses cur_duty=0, then underrun stays 0.
  - Following periods show pwm_out high 64, 128, then 255 clocks of 256.
  - period_stb pulses every 256 clocks.
- Backpressure: with enable=0, push 5 samples into FIFO_DEPTH=4 -> s_ready=0 after the 4th push; the 5th is held by the source. fifo_level=4 and stays 4.
- Underrun: push one sample 0x20, enable, run 3 periods -> cur_duty=0x20 after the 1st boundary; underrun=1 at the 2nd boundary; cur_duty stays 0x20 (0x00 with PWM_UNDERRUN_ZERO_EN). Pulse underrun_clr together with a forced new underrun -> underrun remains 1.
- Prescaler (DIV=4): duty 0x10 -> period 1024 clocks; pwm_out high 64 clocks per period.
- Mid-run control:
  - Drop enable at cnt=100 -> pwm_out=0 next cycle; cnt=0; fifo_level unchanged.
  - Re-enable -> full 256-tick period before the next pop.
  - Assert RST mid-period with 3 queued samples -> fifo_level=0, cur_duty=0.

Source files
------------

// File: rtl/pwm_duty_streamer.sv
// Streams duty-cycle samples through a small FIFO into a PWM generator, updating the duty only at period boundaries.
// Optional: define PWM_UNDERRUN_ZERO_EN to force the duty to zero when a boundary finds the FIFO empty.
module pwm_duty_streamer #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV        = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_data,
  input  logic                          underrun_clr,
  output logic                          pwm_out,
  output logic                          period_stb,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DATA_W-1:0]             cur_duty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [DATA_W-1:0] CNT_LAST = {DATA_W{1'b1}};

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PRE_W-1:0]  presc;
  logic [DATA_W-1:0] cnt;

  logic             push;
  logic             pop;
  logic             tick;
  logic             boundary;
  logic             fifo_empty;
  logic [LVL_W-1:0] level_nxt;

  // Handshake, tick/boundary detection and next FIFO occupancy.
  always_comb begin
    push       = s_valid && s_ready;
    tick       = enable && (presc == PRE_LAST);
    boundary   = tick && (cnt == CNT_LAST);
    fifo_empty = (fifo_level == LVL_W'(0));
    pop        = boundary && !fifo_empty;
    level_nxt  = fifo_level;
    case ({push, pop})
      2'b10:   level_nxt = fifo_level + LVL_W'(1);
      2'b01:   level_nxt = fifo_level - LVL_W'(1);
      default: level_nxt = fifo_level;
    endcase
  end

  // Sample storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO bookkeeping; s_ready tracks the registered level so a full FIFO never bypasses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      s_ready    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_level <= level_nxt;
      s_ready    <= (level_nxt < DEPTH_L);
    end
  end

  // Prescaler and period counter; both park at zero while disabled.
  always_ff @(posedge CLK) begin
    if (RST || !enable) begin
      presc <= '0;
      cnt   <= '0;
    end else if (tick) begin
      presc <= '0;
      cnt   <= cnt + DATA_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  // Duty reload at the boundary, sticky underrun (set beats clear) and registered PWM output.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_duty   <= '0;
      underrun   <= 1'b0;
      period_stb <= 1'b0;
      pwm_out    <= 1'b0;
    end else begin
      if (pop) begin
        cur_duty <= mem[rd_ptr];
      end else if (boundary) begin
`ifdef PWM_UNDERRUN_ZERO_EN
        cur_duty <= '0;
`else
        cur_duty <= cur_duty;
`endif
      end
      if (boundary && fifo_empty) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
      period_stb <= boundary;
      pwm_out    <= enable && (cnt < cur_duty);
    end
  end

endmodule

// File: tb/tb_pwm_duty_streamer.sv
// Randomized/directed bench for pwm_duty_streamer; expected values come from a tick-time model with a sample queue.
module tb_pwm_duty_streamer;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV        = 2;
  localparam int PERIOD_CLK = DIV * (1 << DATA_W);

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              enable = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic              underrun_clr = 1'b0;
  logic              pwm_out;
  logic              period_stb;
  logic              underrun;
  logic [2:0]        fifo_level;
  logic [DATA_W-1:0] cur_duty;

  pwm_duty_streamer #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .underrun_clr(underrun_clr), .pwm_out(pwm_out),
    .period_stb(period_stb), .underrun(underrun), .fifo_level(fifo_level), .cur_duty(cur_duty)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: queued samples, active duty, enabled clocks elapsed since enable rose.
  int q[$];
  int m_duty = 0;
  int m_en_clk = 0;
  bit m_under = 0;
  bit m_stb = 0;
  bit m_pwm = 0;
  bit m_ready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit push;
    bit bnd;
    bit pwm;
    bit was_empty;
    push = 0; bnd = 0; pwm = 0;
    if (RST) begin
      q.delete();
      m_duty = 0; m_en_clk = 0; m_under = 0; m_stb = 0; m_pwm = 0; m_ready = 0;
    end else begin
      push = s_valid && m_ready;
      if (enable) begin
        pwm = ((m_en_clk / DIV) % (1 << DATA_W)) < m_duty;
        bnd = (m_en_clk % PERIOD_CLK) == PERIOD_CLK - 1;
        m_en_clk++;
      end else begin
        m_en_clk = 0;
      end
      was_empty = (q.size() == 0);
      if (bnd && !was_empty) m_duty = q.pop_front();
`ifdef PWM_UNDERRUN_ZERO_EN
      if (bnd && was_empty) m_duty = 0;
`endif
      if (bnd && was_empty) m_under = 1;
      else if (underrun_clr) m_under = 0;
      if (push) q.push_back(int'(s_data));
      m_stb = bnd;
      m_pwm = pwm;
      m_ready = (q.size() < FIFO_DEPTH);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("pwm", pwm_out, m_pwm);
    chk("stb", period_stb, m_stb);
    chk("underrun", underrun, m_under);
    chk("level", fifo_level, q.size());
    chk("duty", cur_duty, m_duty);
    chk("ready", s_ready, m_ready);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_sample(input int v);
    int guard;
    bit accepted;
    guard = 0;
    accepted = 0;
    s_valid = 1'b1;
    s_data = DATA_W'(v);
    while (!accepted && guard < 2000) begin
      accepted = m_ready;
      step();
      guard++;
    end
    if (!accepted) chk("push_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    step();
  endtask

  initial begin
    int highs;
    int stbs;
    int duties[4];
    int rate;
    duties[0] = 0; duties[1] = 'h40; duties[2] = 'h80; duties[3] = 'hFF;

    // Reset held for three cycles, then released.
    run(3);
    RST = 1'b0;
    step();
    chk("rst_ready", s_ready, 32'd1);
    chk("rst_level", fifo_level, 32'd0);
    chk("rst_duty", cur_duty, 32'd0);

    // Steady playback: first period uses duty 0, then the queued samples in order.
    push_sample('h40);
    push_sample('h80);
    push_sample('hFF);
    enable = 1'b1;
    for (int p = 0; p < 4; p++) begin
      highs = 0;
      stbs = 0;
      for (int i = 0; i < PERIOD_CLK; i++) begin
        step();
        highs += int'(pwm_out);
        stbs += int'(period_stb);
      end
      chk("play_highs", highs, DIV * duties[p]);
      chk("play_stbs", stbs, 1);
      if (p < 3) chk("play_no_underrun", underrun, 32'd0);
    end
    chk("play_underrun_end", underrun, 32'd1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("play_clr", underrun, 32'd0);

    // Backpressure with the PWM stopped.
    enable = 1'b0;
    step();
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_data = DATA_W'($urandom);
      step();
    end
    chk("bp_level", fifo_level, 32'd4);
    chk("bp_ready", s_ready, 32'd0);
    s_valid = 1'b0;
    run(3);
    chk("bp_level_hold", fifo_level, 32'd4);

    // Underrun: one sample, three periods, then clear collides with a new underrun.
    do_reset();
    push_sample('h20);
    enable = 1'b1;
    run(PERIOD_CLK);
    chk("ur_duty1", cur_duty, 32'h20);
    chk("ur_flag1", underrun, 32'd0);
    run(PERIOD_CLK);
    chk("ur_flag2", underrun, 32'd1);
`ifdef PWM_UNDERRUN_ZERO_EN
    chk("ur_duty2", cur_duty, 32'h00);
`else
    chk("ur_duty2", cur_duty, 32'h20);
`endif
    run(PERIOD_CLK - 1);
    underrun_clr = 1'b1;
    step();
    chk("ur_set_wins", underrun, 32'd1);
    step();
    underrun_clr = 1'b0;
    chk("ur_cleared", underrun, 32'd0);

    // Mid-run enable drop, re-enable and reset with queued samples.
    enable = 1'b0;
    do_reset();
    push_sample('h90);
    push_sample('h30);
    push_sample('hC0);
    enable = 1'b1;
    run(100 * DIV);
    enable = 1'b0;
    step();
    chk("drop_pwm", pwm_out, 32'd0);
    chk("drop_level", fifo_level, 32'd3);
    enable = 1'b1;
    run(PERIOD_CLK - 1);
    chk("reen_no_pop", fifo_level, 32'd3);
    step();
    chk("reen_pop", fifo_level, 32'd2);
    chk("reen_duty", cur_duty, 32'h90);
    push_sample('h55);
    run(77);
    RST = 1'b1;
    step();
    chk("midrst_level", fifo_level, 32'd0);
    chk("midrst_duty", cur_duty, 32'd0);
    RST = 1'b0;

    // Random playback with varying supply rate, occasional clears, enable toggles and resets.
    enable = 1'b1;
    rate = 50;
    for (int c = 0; c < 9000; c++) begin
      if (c % 1500 == 0) rate = (rate == 50) ? 2 : 50;
      s_valid = (($urandom % 100) < rate);
      s_data = DATA_W'($urandom);
      underrun_clr = (($urandom % 64) == 0);
      if (($urandom % 700) == 0) enable = ~enable;
      RST = (($urandom % 3000) == 0);
      step();
    end
    s_valid = 1'b0;
    underrun_clr = 1'b0;
    RST = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
